// File: rtl/diamond_collect_ctrl_pkg.sv
// Shared game definitions: diamond FSM states, edge-code bit positions and
// the BCD digit type used by the score display.
package diamond_collect_ctrl_pkg;

    typedef enum logic {
        VISIBLE = 1'b0,
        HIDDEN  = 1'b1
    } state_t;

    // Edge code layout is {Left, Top, Right, Bottom}.
    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 0;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/diamond_collect_ctrl_score.sv
// Two-digit BCD score counter that increments on inc and saturates at
// SCORE_MAX.
module bcd_score_counter
    import diamond_collect_ctrl_pkg::*;
#(
    parameter int SCORE_MAX = 99
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       inc,
    output bcd_digit_t tens,
    output bcd_digit_t ones
);

    localparam bcd_digit_t MAX_TENS = bcd_digit_t'(SCORE_MAX / 10);
    localparam bcd_digit_t MAX_ONES = bcd_digit_t'(SCORE_MAX % 10);

    logic at_max;
    assign at_max = (tens == MAX_TENS) && (ones == MAX_ONES);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            tens <= '0;
            ones <= '0;
        end else if (inc && !at_max) begin
            if (ones == 4'd9) begin
                ones <= '0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/diamond_collect_ctrl.sv
// Diamond collect controller: records player/diamond overlap during a frame,
// commits a collect at the next start of frame, then hides the diamond.
module diamond_collect_ctrl
    import diamond_collect_ctrl_pkg::*;
#(
    parameter int RESPAWN_FRAMES = 120,
    parameter int SCORE_MAX      = 99
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       diamondDrawingRequest,
    input  logic       playerDrawingRequest,
    input  logic [3:0] diamondHitEdgeCode,
    output logic       drawingRequest,
    output logic       collectPulse,
    output logic [3:0] collectEdge,
    output logic [3:0] scoreTens,
    output logic [3:0] scoreOnes
);

    state_t     state;
    state_t     state_next;
    logic       hit_flag;
    logic [3:0] edge_acc;
    logic [7:0] frame_cnt;
    logic       overlap;
    logic       commit;

    assign overlap        = (state == VISIBLE) && diamondDrawingRequest && playerDrawingRequest;
    assign commit         = startOfFrame && (state == VISIBLE) && hit_flag;
    assign drawingRequest = diamondDrawingRequest && (state == VISIBLE);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state <= VISIBLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            VISIBLE: if (commit) state_next = HIDDEN;
            HIDDEN:  if (startOfFrame && frame_cnt <= 8'd1) state_next = VISIBLE;
            default: state_next = VISIBLE;
        endcase
    end

    // NOTE: all registered state uses non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            hit_flag <= 1'b0;
            edge_acc <= '0;
        end else if (startOfFrame) begin
            // The clear at frame start loses to an overlap in the same cycle.
            hit_flag <= overlap;
            edge_acc <= overlap ? diamondHitEdgeCode : 4'h0;
        end else if (overlap) begin
            hit_flag <= 1'b1;
            edge_acc <= edge_acc | diamondHitEdgeCode;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            frame_cnt    <= '0;
            collectPulse <= 1'b0;
            collectEdge  <= '0;
        end else begin
            collectPulse <= commit;
            if (commit) begin
                frame_cnt   <= 8'(RESPAWN_FRAMES);
                collectEdge <= edge_acc;
            end else if (state == HIDDEN && startOfFrame && frame_cnt != 8'd0) begin
                frame_cnt <= frame_cnt - 8'd1;
            end
        end
    end

    bcd_score_counter #(
        .SCORE_MAX(SCORE_MAX)
    ) u_score (
        .clk   (clk),
        .resetN(resetN),
        .inc   (commit),
        .tens  (scoreTens),
        .ones  (scoreOnes)
    );

endmodule

// File: doc/diamond_collect_ctrl.md
DIAMOND_COLLECT_CTRL -- requirements
Module: diamond_collect_ctrl

Interface
REQ-001 Parameter RESPAWN_FRAMES, default 120, sets the number of full frames the diamond stays hidden after a collect (range 1..255).
REQ-002 Parameter SCORE_MAX, default 99, sets the decimal saturation value of the score (range 1..99).
REQ-003 clk  input  1  system clock; the block uses one clock, and all state is updated on the rising edge.
REQ-004 resetN  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 startOfFrame  input  1  one-cycle pulse marking the first pixel of each frame.
REQ-006 diamondDrawingRequest  input  1  diamond bitmap pixel is opaque.
REQ-007 playerDrawingRequest  input  1  player bitmap pixel is opaque.
REQ-008 diamondHitEdgeCode  input  4  diamond edge code for the current pixel, as {Left, Top, Right, Bottom}.
REQ-009 drawingRequest  output  1  gated diamond draw request sent to the objects mux.
REQ-010 collectPulse  output  1  one-cycle pulse when a collect is committed.
REQ-011 collectEdge  output  4  OR of the edge codes seen on overlapping pixels during the committed frame.
REQ-012 scoreTens, scoreOnes  output  4 each  BCD score.

Function
REQ-013 The FSM SHALL have exactly two states: VISIBLE and HIDDEN.
REQ-014 drawingRequest SHALL equal diamondDrawingRequest AND (state==VISIBLE), combinationally with no added latency.
REQ-015 An overlap pixel SHALL be any cycle in which the state is VISIBLE and both diamondDrawingRequest and playerDrawingRequest are 1.
REQ-016 On each overlap pixel, the block SHALL set hitFlag and SHALL OR diamondHitEdgeCode into edgeAcc.
REQ-017 On a startOfFrame cycle while VISIBLE with hitFlag=1, the block SHALL, at that clock edge, assert collectPulse for the next cycle only, load collectEdge from edgeAcc, increment the BCD score, load frameCnt with RESPAWN_FRAMES, and enter HIDDEN.
REQ-018 On every startOfFrame cycle, hitFlag and edgeAcc SHALL be cleared; an overlap occurring in the startOfFrame cycle itself SHALL count toward the new frame (clear followed by set results in set).
REQ-019 In HIDDEN, frameCnt SHALL decrement on each startOfFrame; when it reaches 0 on a startOfFrame, the state SHALL return to VISIBLE.
REQ-020 Overlaps SHALL NOT be recorded while HIDDEN, so no collect can be committed in HIDDEN.
REQ-021 BCD increment SHALL work as follows: ones 9->0 with tens+1; when the score equals SCORE_MAX it SHALL hold, while collectPulse still fires.
REQ-022 collectEdge SHALL hold its value until the next collect.
REQ-023 If startOfFrame is not seen, the state SHALL remain unchanged indefinitely; there is no timeout.
REQ-024 The latency from the last overlap pixel of a frame to collectPulse SHALL be the next startOfFrame plus 1 cycle.

Reset
REQ-025 While resetN=0, at each rising clk edge: state=VISIBLE, hitFlag=0, edgeAcc=0, frameCnt=0, collectPulse=0, collectEdge=4'h0, scoreTens=0, scoreOnes=0.
REQ-026 A reset asserted in the middle of a frame or while HIDDEN SHALL discard pending hits and the hide countdown; the diamond SHALL be visible on the first cycle after release.
REQ-027 drawingRequest SHALL follow REQ-014 during reset, with state forced to VISIBLE.

Structure
REQ-028 The state enum (VISIBLE, HIDDEN), the edge-code bit positions (LEFT=3, TOP=2, RIGHT=1, BOTTOM=0) and the 4-bit BCD digit type SHALL reside in the shared game package.
REQ-029 The BCD counter SHALL be a separate sub-module, bcd_score_counter (inputs: clk, resetN, inc; outputs: tens, ones; saturates at SCORE_MAX).

Verification
REQ-030 Scenario: overlap on 3 pixels in frame N, with edge codes 4'h8, 4'h8, 4'hC -> collectPulse one cycle after the startOfFrame of frame N+1; collectEdge=4'hC; score 00->01; drawingRequest=0 thereafter.
REQ-031 Scenario: with RESPAWN_FRAMES=3, collect, then 3 startOfFrame pulses -> drawingRequest is re-enabled right after the 3rd pulse; overlaps during HIDDEN produce no pulse and no score change.
REQ-032 Scenario: overlap in the same cycle as startOfFrame -> no pulse at that edge; pulse at the following startOfFrame.
REQ-033 Scenario: score preloaded to 09 via 9 collects, then 1 collect -> tens=1, ones=0; with SCORE_MAX=12, a 13th collect -> score stays 12 and collectPulse=1.
REQ-034 Scenario: resetN=0 for 1 cycle while HIDDEN with frameCnt=50 -> state VISIBLE, score 00, collectEdge 0 on the next cycle.
REQ-035 Scenario: playerDrawingRequest=1 with diamondDrawingRequest=0 for an entire frame -> no collect.
